vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between VGA scan-out and a host (Arduino command) port. Sits between `vga_timing_gen` and the colour output stage. Scan-out always wins its fixed slots; host reads and writes use the remaining cycles. Sync/active signals are delayed to stay aligned with the fetched pixel. The framebuffer is 160x120, 4-bit pixels, each pixel drawn as a 4x4 block.

---
 rtl/vram_arbiter_if.sv | 25 ++
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Host command port of the VRAM arbiter.
// master : host side (drives the request, receives ready and the read response)
// slave  : arbiter side
//   req_valid/req_we/req_addr/req_wdata  host request (valid/ready handshake)
//   req_ready                            request accepted this cycle (combinational)
//   rsp_valid/rsp_rdata                  one-cycle read-response strobe and data
interface vram_arbiter_if;
   logic        req_valid;
   logic        req_we;
   logic [14:0] req_addr;
   logic [3:0]  req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [3:0]  rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous video RAM between VGA scan-out and a host port.
// Scan-out owns every active cycle with x[1:0]==0; the host uses all other cycles.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   hs_in/vs_in/active_in, x, y  timing generator inputs
//   host                       host request/response port (vram_arbiter_if.slave)
//   mem_en/we/addr/wdata       registered RAM command, mem_rdata one cycle later
//   pixel                      pixel colour, 0 outside active video
//   hs_out/vs_out/active_out   timing inputs delayed 3 cycles to align with pixel
module vram_arbiter (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hs_in,
   input  logic                 vs_in,
   input  logic                 active_in,
   input  logic [9:0]           x,
   input  logic [8:0]           y,
   vram_arbiter_if.slave        host,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [14:0]          mem_addr,
   output logic [3:0]           mem_wdata,
   input  logic [3:0]           mem_rdata,
   output logic [3:0]           pixel,
   output logic                 hs_out,
   output logic                 vs_out,
   output logic                 active_out
);

   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_WORDS = FB_W * 120;
   localparam int unsigned AW       = 15;
   localparam int unsigned DW       = 4;
   localparam int unsigned DLY      = 3;

   // What the RAM op issued in a given cycle returns to
   typedef enum logic [1:0] {
      TAG_NONE  = 2'd0,
      TAG_SCAN  = 2'd1,
      TAG_HRD   = 2'd2,
      TAG_HOOR  = 2'd3
   } tag_t;

   logic          scan_slot;
   logic          accept;
   logic          in_range;
   logic [AW-1:0] scan_addr;
   logic          unused_y;

   logic          mem_en_q,    mem_en_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   tag_t          tag0_q,      tag0_d;
   tag_t          tag1_q;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [DW-1:0] pix_q,       pix_d;
   logic [DLY-1:0] hs_dly_q, vs_dly_q, act_dly_q;

   // Arbitration: scan slot has absolute priority
   assign scan_slot = active_in & (x[1:0] == 2'b00);
   assign accept    = host.req_valid & ~scan_slot;
   assign in_range  = host.req_addr < AW'(FB_WORDS);

   // y/4*160 + x/4 as shift-adds (160 = 128 + 32)
   assign scan_addr = (AW'(y[8:2]) << 7) + (AW'(y[8:2]) << 5) + AW'(x[9:2]);
   assign unused_y  = ^y[1:0];

   // Next RAM command and the tag describing where its data goes
   always_comb begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tag0_d      = TAG_NONE;
      if (scan_slot) begin
         mem_en_d   = 1'b1;
         mem_addr_d = scan_addr;
         tag0_d     = TAG_SCAN;
      end else if (accept) begin
         if (in_range) begin
            mem_en_d   = 1'b1;
            mem_we_d   = host.req_we;
            mem_addr_d = host.req_addr;
            if (host.req_we) begin
               mem_wdata_d = host.req_wdata;
            end else begin
               tag0_d = TAG_HRD;
            end
         end else if (!host.req_we) begin
            tag0_d = TAG_HOOR;
         end
      end
   end

   // Capture returning read data according to the tag of the op that produced it
   always_comb begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      pix_d       = pix_q;
      case (tag1_q)
         TAG_SCAN: pix_d = mem_rdata;
         TAG_HRD: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata;
         end
         TAG_HOOR: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag0_q      <= TAG_NONE;
         tag1_q      <= TAG_NONE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         pix_q       <= '0;
         hs_dly_q    <= '0;
         vs_dly_q    <= '0;
         act_dly_q   <= '0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag0_q      <= tag0_d;
         tag1_q      <= tag0_q;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         pix_q       <= pix_d;
         hs_dly_q    <= {hs_dly_q[DLY-2:0],  hs_in};
         vs_dly_q    <= {vs_dly_q[DLY-2:0],  vs_in};
         act_dly_q   <= {act_dly_q[DLY-2:0], active_in};
      end
   end

   assign host.req_ready = ~scan_slot;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_rdata = rsp_rdata_q;
   assign mem_en         = mem_en_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign hs_out         = hs_dly_q[DLY-1];
   assign vs_out         = vs_dly_q[DLY-1];
   assign active_out     = act_dly_q[DLY-1];
   assign pixel          = active_out ? pix_q : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scan-address table, hand-written corner
// sequences, then randomized traffic against a cycle-scheduled reference model.
module tb_vram_arbiter;

   localparam int unsigned FB_WORDS = 19200;
   localparam int unsigned N_RAND   = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs_in, vs_in, active_in;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [3:0]  mem_wdata;
   logic [3:0]  mem_rdata = 4'h0;
   logic [3:0]  pixel;
   logic        hs_out, vs_out, active_out;

   vram_arbiter_if hif ();

   vram_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hs_in      (hs_in),
      .vs_in      (vs_in),
      .active_in  (active_in),
      .x          (x),
      .y          (y),
      .host       (hif),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .pixel      (pixel),
      .hs_out     (hs_out),
      .vs_out     (vs_out),
      .active_out (active_out)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM: one-cycle read latency
   logic [3:0] ram [FB_WORDS];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic act, input int unsigned xx, input int unsigned yy,
                        input logic rv, input logic rwe, input int unsigned ra,
                        input int unsigned rd);
      active_in     = act;
      x             = 10'(xx);
      y             = 9'(yy);
      hif.req_valid = rv;
      hif.req_we    = rwe;
      hif.req_addr  = 15'(ra);
      hif.req_wdata = 4'(rd);
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   typedef struct {
      int unsigned x;
      int unsigned y;
      int unsigned addr;
   } scan_vec_t;

   scan_vec_t svec [5];

   // Reference model schedule: RAM command expected at c+1, outputs at c+3
   logic [3:0] ref_fb [FB_WORDS];
   bit          em_set [8];
   bit          em_en  [8];
   bit          em_we  [8];
   int unsigned em_addr [8];
   int unsigned em_wd  [8];
   bit          eo_set [8];
   bit          eo_hs  [8];
   bit          eo_vs  [8];
   bit          eo_act [8];
   bit          eo_rv  [8];
   int unsigned eo_rd  [8];
   bit          eo_pld [8];
   int unsigned eo_pv  [8];
   int unsigned pix_m;

   initial begin
      svec[0] = '{x: 4,   y: 8,   addr: 321};
      svec[1] = '{x: 636, y: 479, addr: 19199};
      svec[2] = '{x: 0,   y: 0,   addr: 0};
      svec[3] = '{x: 8,   y: 4,   addr: 162};
      svec[4] = '{x: 320, y: 240, addr: 9680};

      hs_in = 1'b0;
      vs_in = 1'b0;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_mem_en",    mem_en, 0);
      chk("reset_mem_addr",  mem_addr, 0);
      chk("reset_rsp_valid", hif.rsp_valid, 0);
      chk("reset_pixel",     pixel, 0);
      rst_n = 1'b1;

      // Preload through the host port during blanking
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b1, 321, 4'hA);
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b1, 10, 1);
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b1, 11, 2);
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b1, 12, 3);
      tick(); idle();
      tick(); tick();

      // Scan address table
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1'b1, svec[i].x, svec[i].y, 1'b0, 1'b0, 0, 0);
         #1 chk("scan_tbl_ready", hif.req_ready, 0);
         tick();
         chk("scan_tbl_en",   mem_en, 1);
         chk("scan_tbl_we",   mem_we, 0);
         chk("scan_tbl_addr", mem_addr, svec[i].addr);
         idle();
      end
      tick(); tick(); tick();

      // Scan fetch of 321: pixel 0xA during t+3..t+6
      tick();
      drive(1'b1, 4, 8, 1'b0, 1'b0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            chk("scan_px_en",   mem_en, 1);
            chk("scan_px_addr", mem_addr, 321);
         end
         if (k == 2) chk("scan_px_early", pixel, 0);
         if (k >= 3) chk("scan_px_pixel", pixel, 4'hA);
         drive(1'b1, 5 + (k % 3), 8, 1'b0, 1'b0, 0, 0);
      end
      tick(); idle();
      tick(); tick(); tick();
      chk("blank_active_out", active_out, 0);
      chk("blank_pixel",      pixel, 0);

      // Collision: write held across a scan slot
      tick();
      drive(1'b1, 0, 0, 1'b1, 1'b1, 5, 3);
      #1 chk("coll_ready_slot", hif.req_ready, 0);
      tick();
      chk("coll_scan_we",   mem_we, 0);
      chk("coll_scan_addr", mem_addr, 0);
      drive(1'b1, 1, 0, 1'b1, 1'b1, 5, 3);
      #1 chk("coll_ready_next", hif.req_ready, 1);
      tick();
      chk("coll_en",    mem_en, 1);
      chk("coll_we",    mem_we, 1);
      chk("coll_addr",  mem_addr, 5);
      chk("coll_wdata", mem_wdata, 3);
      idle();
      tick(); tick(); tick();

      // Back-to-back host reads
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b0, 10, 0);
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b0, 11, 0);
      tick(); chk("rd_not_early", hif.rsp_valid, 0);
      drive(1'b0, 0, 0, 1'b1, 1'b0, 12, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rd_valid", hif.rsp_valid, 1);
         chk("rd_data",  hif.rsp_rdata, k + 1);
         idle();
      end
      tick(); chk("rd_valid_end", hif.rsp_valid, 0);

      // Reset with a host read in flight
      hs_in = 1'b1;
      vs_in = 1'b1;
      repeat (3) tick();
      tick(); drive(1'b1, 1, 20, 1'b1, 1'b0, 10, 0);
      tick(); drive(1'b1, 2, 20, 1'b0, 1'b0, 0, 0);
      chk("prerst_hs_out", hs_out, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mem_en",     mem_en, 0);
      chk("rst_mem_addr",   mem_addr, 0);
      chk("rst_mem_wdata",  mem_wdata, 0);
      chk("rst_rsp_rdata",  hif.rsp_rdata, 0);
      chk("rst_rsp_valid",  hif.rsp_valid, 0);
      chk("rst_hs_out",     hs_out, 0);
      chk("rst_vs_out",     vs_out, 0);
      chk("rst_active_out", active_out, 0);
      chk("rst_pixel",      pixel, 0);
      hs_in = 1'b0;
      vs_in = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("postrst_rsp_valid", hif.rsp_valid, 0);
         chk("postrst_pixel",     pixel, 0);
         drive(1'b1, 1 + (k % 3), 30, 1'b0, 1'b0, 0, 0);
      end
      tick(); idle();
      tick(); tick(); tick();

      // In-range read then out-of-range write and read
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b0, 10, 0);
      tick(); drive(1'b0, 0, 0, 1'b1, 1'b1, 19200, 4'hF);
      #1 chk("oor_wr_ready", hif.req_ready, 1);
      tick();
      chk("oor_wr_en", mem_en, 0);
      chk("oor_wr_we", mem_we, 0);
      drive(1'b0, 0, 0, 1'b1, 1'b0, 20000, 0);
      #1 chk("oor_rd_ready", hif.req_ready, 1);
      tick();
      chk("oor_rd_en", mem_en, 0);
      chk("pre_oor_valid", hif.rsp_valid, 1);
      chk("pre_oor_data",  hif.rsp_rdata, 1);
      idle();
      tick(); chk("oor_gap_valid", hif.rsp_valid, 0);
      tick();
      chk("oor_rd_valid", hif.rsp_valid, 1);
      chk("oor_rd_data",  hif.rsp_rdata, 0);
      tick(); tick(); tick();

      // Randomized traffic against the reference model
      rst_n = 1'b0;
      tick(); tick();
      for (int i = 0; i < FB_WORDS; i++) ref_fb[i] = ram[i];
      for (int i = 0; i < 8; i++) begin
         em_set[i] = 1'b0;
         eo_set[i] = 1'b0;
      end
      pix_m = 0;
      rst_n = 1'b1;
      for (int c = 0; c < N_RAND; c++) begin
         logic [2:0]  s, m, o;
         logic        act, rv, rwe, hs, vs;
         int unsigned xx, yy, ra, rd, a;
         tick();
         s = 3'(c);
         if (em_set[s]) begin
            chk("rnd_mem_en", mem_en, em_en[s]);
            chk("rnd_mem_we", mem_we, em_we[s]);
            if (em_en[s]) chk("rnd_mem_addr", mem_addr, em_addr[s]);
            if (em_we[s]) chk("rnd_mem_wdata", mem_wdata, em_wd[s]);
            em_set[s] = 1'b0;
         end
         if (eo_set[s]) begin
            if (eo_pld[s]) pix_m = eo_pv[s];
            chk("rnd_hs_out",     hs_out, eo_hs[s]);
            chk("rnd_vs_out",     vs_out, eo_vs[s]);
            chk("rnd_active_out", active_out, eo_act[s]);
            chk("rnd_rsp_valid",  hif.rsp_valid, eo_rv[s]);
            if (eo_rv[s]) chk("rnd_rsp_rdata", hif.rsp_rdata, eo_rd[s]);
            chk("rnd_pixel", pixel, eo_act[s] ? pix_m : 0);
            eo_set[s] = 1'b0;
         end

         act = ($urandom_range(0, 3) != 0);
         xx  = $urandom_range(0, 639);
         yy  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 479);
         hs  = 1'($urandom_range(0, 1));
         vs  = 1'($urandom_range(0, 1));
         rv  = ($urandom_range(0, 2) != 0);
         rwe = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       ra = $urandom_range(FB_WORDS, 32767);
            1:       ra = $urandom_range(0, FB_WORDS - 1);
            default: ra = $urandom_range(0, 63);
         endcase
         rd = $urandom_range(0, 15);
         hs_in = hs;
         vs_in = vs;
         drive(act, xx, yy, rv, rwe, ra, rd);
         #1 chk("rnd_ready", hif.req_ready, (act && (xx % 4 == 0)) ? 0 : 1);

         m = 3'(c + 1);
         o = 3'(c + 3);
         em_set[m] = 1'b1;
         em_en[m]  = 1'b0;
         em_we[m]  = 1'b0;
         eo_set[o] = 1'b1;
         eo_hs[o]  = hs;
         eo_vs[o]  = vs;
         eo_act[o] = act;
         eo_rv[o]  = 1'b0;
         eo_pld[o] = 1'b0;
         if (act && (xx % 4 == 0)) begin
            a = (yy / 4) * 160 + xx / 4;
            em_en[m]   = 1'b1;
            em_addr[m] = a;
            eo_pld[o]  = 1'b1;
            eo_pv[o]   = ref_fb[15'(a)];
         end else if (rv) begin
            if (ra < FB_WORDS) begin
               em_en[m]   = 1'b1;
               em_we[m]   = rwe;
               em_addr[m] = ra;
               em_wd[m]   = rd;
               if (rwe) begin
                  ref_fb[15'(ra)] = 4'(rd);
               end else begin
                  eo_rv[o] = 1'b1;
                  eo_rd[o] = ref_fb[15'(ra)];
               end
            end else if (!rwe) begin
               eo_rv[o] = 1'b1;
               eo_rd[o] = 0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
